// File: rtl/pattern_hit_logger.sv
// Timestamps '3393' hits with the digit index that completed the pattern, queues the stamps
// in a show-ahead FIFO, and keeps a saturating BCD hit total plus overflow/drop bookkeeping.
module pattern_hit_logger #(
  parameter int POS_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     sample_en,
  input  logic                     hit,
  input  logic                     rd_en,
  output logic [POS_W-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [15:0]              hit_bcd
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt, rd_ptr_nxt, level_nxt;
  logic [POS_W-1:0] head_nxt;
  logic             qhit, push, pop, drop, full_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Four-digit BCD increment that sticks at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    qhit       = hit & sample_en;
    pop        = rd_en & ~empty;
    push       = qhit & (~full | pop);
    drop       = qhit & full & ~pop;
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                 (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
    // A push landing on the next head slot is not in mem yet, so forward it.
    if (push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
      head_nxt = pos;
    else
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && push)
      mem[wr_ptr[AW-1:0]] <= pos;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      hit_bcd  <= 16'h0000;
      rd_data  <= '0;
    end else if (clear) begin
      pos      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      hit_bcd  <= 16'h0000;
      rd_data  <= '0;
    end else begin
      pos    <= pos + POS_W'(sample_en);
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
      empty  <= (level_nxt == '0);
      full   <= full_nxt;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc(drop_cnt);
      end
      if (qhit)
        hit_bcd <= bcd_inc(hit_bcd);
      // rd_data keeps its last value once the FIFO runs empty.
      if (level_nxt != '0)
        rd_data <= head_nxt;
    end
  end

endmodule

// File: doc/pattern_hit_logger.md
Name: pattern_hit_logger

Overview:
- Sits directly downstream of the '3393' pattern identifier and consumes its hit pulse.
- Keeps a running sample index for the digit stream and stamps each hit with the index of the digit that completed the pattern.
- Queues the stamps in a small FIFO that a host or display controller drains through a read handshake.
- Keeps a 4-digit BCD hit total for the 7-segment display, plus overflow/drop bookkeeping.

Parameters:
- POS_W, 16, width of the sample index counter and of each FIFO entry.
- DEPTH, 4, FIFO depth in entries; must be a power of two, at least 2.
- CNT_W, 8, width of the dropped-hit counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- clear  input  1  synchronous clear of all counters, FIFO and flags.
- sample_en  input  1  a digit was presented to the identifier this cycle.
- hit  input  1  identifier hit output; qualified by sample_en.
- rd_en  input  1  pop request for the FIFO head.
- rd_data  output  POS_W  sample index at the FIFO head (show-ahead).
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: at least one hit was dropped.
- drop_cnt  output  CNT_W  number of dropped hits, saturating.
- hit_bcd  output  16  BCD hit total, 4 digits, thousands digit in [15:12].

Behaviour:
- Reset (rst=1, asynchronous): pos=0, FIFO pointers=0, level=0, empty=1, full=0, overflow=0, drop_cnt=0, hit_bcd=16'h0000, rd_data=0.
- Priority order: rst, then clear, then normal operation.
- clear=1 at a clock edge: same values as reset. hit, sample_en and rd_en are ignored in that cycle.
- Sample index: pos increments by 1 on every edge with sample_en=1 and wraps from 2^POS_W-1 to 0.
- A qualified hit is hit=1 together with sample_en=1. hit while sample_en=0 is ignored.
- Push: a qualified hit writes the pre-increment pos value. Example: the first sample after reset is index 0.
- Pop: rd_en=1 while empty=0 advances the head. rd_en while empty is ignored, with no error flag.
- rd_data always shows mem[rd_ptr] and is valid only while empty=0. When empty it holds its last value (0 after reset).
- Latency: a pushed entry is visible on rd_data, with empty=0, one cycle after the push edge.
- Full with a qualified hit and no pop: the entry is dropped, overflow is set, and drop_cnt increments, saturating at 2^CNT_W-1. The FIFO contents are unchanged.
- Full with a qualified hit and a pop in the same cycle: both happen, level stays DEPTH, and nothing is dropped.
- Empty with a push and rd_en in the same cycle: only the push takes effect, and level becomes 1.
- level/empty/full are registered and consistent with the pointers after every edge.
- Pointer width is $clog2(DEPTH)+1; full is detected by MSB-differ / LSBs-equal.
- hit_bcd increments on every qualified hit, including dropped ones.
  - BCD carry: a digit at 9 rolls to 0 and carries into the next digit.
  - The count saturates at 9999 and never wraps.
- Reset mid-operation clears everything immediately, without waiting for a clock edge. Entries in flight are lost.

Test Plan:
1. rst pulse, then sample_en=1 continuously with hit=1 at indices 9 and 17, no reads. Required: level=2, rd_data=9, hit_bcd=16'h0002, overflow=0.
2. Continue from 1 with rd_en=1 for 3 cycles. Required: rd_data goes 9 then 17, empty=1 after the second pop, the third rd_en is ignored, level=0.
3. Five qualified hits at indices 20..24 with no reads (DEPTH=4). Required: full=1 after the 4th, the 5th is dropped, overflow=1, drop_cnt=1, FIFO drains 20,21,22,23, hit_bcd increments by 5.
4. FIFO full, qualified hit at index 30 with rd_en=1 in the same cycle. Required: level stays 4, no drop, the newest tail entry is 30. Also check hit=1 with sample_en=0: no push, pos unchanged.
5. Preload hit_bcd to 0099 with 99 hits, then one more. Required: 16'h0100. Drive to 9999, then one more hit: stays 16'h9999.
6. Assert rst asynchronously between edges while level=3; separately, pulse clear together with a qualified hit. Required in both cases: all outputs return to reset values, and the hit coinciding with clear is not recorded.
